mac_operand_sequencer: RTL and testbench

Upstream feeder for the 16-bit MAC unit. Buffers incoming operand pairs in a small FIFO and, on command, issues one dot-product vector of `vec_len` pairs to the MAC at one pair per cycle. It also produces an accumulator-clear pulse before the first pair, a last-pair flag, and a completion pulse. All MAC-facing outputs are registered so they can drive the MAC directly.

---
 rtl/mac_operand_sequencer.sv | 96 +++++++++
 tb/tb_mac_operand_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: FIFO-buffered operand feeder issuing dot-product vectors to a 16-bit MAC
module mac_operand_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             mac_hold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic [15:0]      multiplier,
  output logic [15:0]      multiplicand,
  output logic             op_valid,
  output logic             acc_clear,
  output logic             op_last,
  output logic             busy,
  output logic             done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  state_t           state;
  logic [31:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [LEN_W-1:0] remaining;
  logic             push, pop;
  assign in_ready = count < CW'(DEPTH);
  assign push     = in_valid && in_ready;
  // Issue is decided while CLEAR is on the outputs so the first pair lands right after acc_clear
  assign pop      = (state == CLEAR || state == RUN) && remaining != '0 && count != '0 && !mac_hold;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_a, in_b};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  // RUN lingers one cycle after the last issue so op_last is shown before done
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= IDLE;
      remaining    <= '0;
      multiplier   <= '0;
      multiplicand <= '0;
      op_valid     <= 1'b0;
      acc_clear    <= 1'b0;
      op_last      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      acc_clear <= 1'b0;
      done      <= 1'b0;
      op_valid  <= pop;
      op_last   <= pop && remaining == LEN_W'(1);
      if (pop) begin
        {multiplier, multiplicand} <= mem[rd_ptr];
        remaining                  <= remaining - LEN_W'(1);
      end
      case (state)
        IDLE:
          if (start) begin
            busy <= 1'b1;
            if (vec_len != '0) begin
              state        <= CLEAR;
              remaining    <= vec_len;
              acc_clear    <= 1'b1;
              multiplier   <= '0;
              multiplicand <= '0;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        CLEAR: state <= RUN;
        RUN:
          if (remaining == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer: directed cycle tables for mac_operand_sequencer with a MAC accumulator model
module tb_mac_operand_sequencer;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, mac_hold = 1'b0, in_valid = 1'b0;
  logic [7:0]  vec_len = 8'd0;
  logic [15:0] in_a = 16'd0, in_b = 16'd0, multiplier, multiplicand;
  logic        in_ready, op_valid, acc_clear, op_last, busy, done;
  logic [31:0] acc = 32'd0;
  int          n_chk = 0, n_fail = 0, issues = 0;
  typedef struct {
    logic        st;
    logic [7:0]  len;
    logic        hold;
    logic        iv;
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  ef;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;
  vec_t basic[10], starve[14], full[14], fill[4], zero[3], ign[6], pre[4], post[8];
  mac_operand_sequencer #(.DEPTH(4), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .mac_hold(mac_hold),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .multiplier(multiplier), .multiplicand(multiplicand), .op_valid(op_valid),
    .acc_clear(acc_clear), .op_last(op_last), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (acc_clear) acc <= 32'd0;
    else if (op_valid) acc <= acc + multiplier * multiplicand;
    if (op_valid) issues <= issues + 1;
  end
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic apply(input string nm, input vec_t v);
    start = v.st;
    vec_len = v.len;
    mac_hold = v.hold;
    in_valid = v.iv;
    in_a = v.a;
    in_b = v.b;
    check(nm, {26'd0, op_valid, acc_clear, op_last, busy, done, in_ready, multiplier, multiplicand},
          {26'd0, v.ef, v.ea, v.eb});
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    // flags: {op_valid, acc_clear, op_last, busy, done, in_ready}
    basic = '{
      '{1'b0, 8'd0, 1'b0, 1'b1, 16'd2, 16'd3, 6'b000001, 16'd0, 16'd0},
      '{1'b0, 8'd0, 1'b0, 1'b1, 16'd4, 16'd5, 6'b000001, 16'd0, 16'd0},
      '{1'b0, 8'd0, 1'b0, 1'b1, 16'd6, 16'd7, 6'b000001, 16'd0, 16'd0},
      '{1'b1, 8'd3, 1'b0, 1'b0, 16'd0, 16'd0, 6'b000001, 16'd0, 16'd0},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b010101, 16'd0, 16'd0},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b100101, 16'd2, 16'd3},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b100101, 16'd4, 16'd5},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b101101, 16'd6, 16'd7},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b000111, 16'd6, 16'd7},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b000001, 16'd6, 16'd7}
    };
    starve = '{
      '{1'b1, 8'd4, 1'b0, 1'b0, 16'd0,  16'd0, 6'b000001, 16'd6,  16'd7},
      '{1'b0, 8'd0, 1'b0, 1'b1, 16'd10, 16'd1, 6'b010101, 16'd0,  16'd0},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0,  16'd0, 6'b000101, 16'd0,  16'd0},
      '{1'b0, 8'd0, 1'b0, 1'b1, 16'd20, 16'd2, 6'b100101, 16'd10, 16'd1},
      '{1'b0, 8'd0, 1'b1, 1'b1, 16'd30, 16'd3, 6'b000101, 16'd10, 16'd1},
      '{1'b0, 8'd0, 1'b1, 1'b0, 16'd0,  16'd0, 6'b000101, 16'd10, 16'd1},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0,  16'd0, 6'b000101, 16'd10, 16'd1},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0,  16'd0, 6'b100101, 16'd20, 16'd2},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0,  16'd0, 6'b100101, 16'd30, 16'd3},
      '{1'b0, 8'd0, 1'b0, 1'b1, 16'd40, 16'd4, 6'b000101, 16'd30, 16'd3},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0,  16'd0, 6'b000101, 16'd30, 16'd3},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0,  16'd0, 6'b101101, 16'd40, 16'd4},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0,  16'd0, 6'b000111, 16'd40, 16'd4},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0,  16'd0, 6'b000001, 16'd40, 16'd4}
    };
    full = '{
      '{1'b0, 8'd0, 1'b0, 1'b1, 16'd1, 16'd1, 6'b000001, 16'd40, 16'd4},
      '{1'b0, 8'd0, 1'b0, 1'b1, 16'd2, 16'd2, 6'b000001, 16'd40, 16'd4},
      '{1'b0, 8'd0, 1'b0, 1'b1, 16'd3, 16'd3, 6'b000001, 16'd40, 16'd4},
      '{1'b0, 8'd0, 1'b0, 1'b1, 16'd4, 16'd4, 6'b000001, 16'd40, 16'd4},
      '{1'b0, 8'd0, 1'b0, 1'b1, 16'd5, 16'd5, 6'b000000, 16'd40, 16'd4},
      '{1'b0, 8'd0, 1'b0, 1'b1, 16'd6, 16'd6, 6'b000000, 16'd40, 16'd4},
      '{1'b1, 8'd4, 1'b0, 1'b0, 16'd0, 16'd0, 6'b000000, 16'd40, 16'd4},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b010100, 16'd0,  16'd0},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b100101, 16'd1,  16'd1},
      '{1'b0, 8'd0, 1'b0, 1'b1, 16'd7, 16'd7, 6'b100101, 16'd2,  16'd2},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b100101, 16'd3,  16'd3},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b101101, 16'd4,  16'd4},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b000111, 16'd4,  16'd4},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b000001, 16'd4,  16'd4}
    };
    fill = '{
      '{1'b0, 8'd0, 1'b0, 1'b1, 16'd8,  16'd8,  6'b000001, 16'd4, 16'd4},
      '{1'b0, 8'd0, 1'b0, 1'b1, 16'd9,  16'd9,  6'b000001, 16'd4, 16'd4},
      '{1'b0, 8'd0, 1'b0, 1'b1, 16'd10, 16'd10, 6'b000001, 16'd4, 16'd4},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0,  16'd0,  6'b000000, 16'd4, 16'd4}
    };
    zero = '{
      '{1'b1, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b000000, 16'd4, 16'd4},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b000110, 16'd4, 16'd4},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b000000, 16'd4, 16'd4}
    };
    ign = '{
      '{1'b1, 8'd2, 1'b0, 1'b0, 16'd0, 16'd0, 6'b000000, 16'd4, 16'd4},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b010100, 16'd0, 16'd0},
      '{1'b1, 8'd3, 1'b0, 1'b0, 16'd0, 16'd0, 6'b100101, 16'd7, 16'd7},
      '{1'b1, 8'd3, 1'b0, 1'b0, 16'd0, 16'd0, 6'b101101, 16'd8, 16'd8},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b000111, 16'd8, 16'd8},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b000001, 16'd8, 16'd8}
    };
    pre = '{
      '{1'b1, 8'd5, 1'b0, 1'b0, 16'd0, 16'd0, 6'b000001, 16'd8,  16'd8},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b010101, 16'd0,  16'd0},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b100101, 16'd9,  16'd9},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 16'd0, 6'b100101, 16'd10, 16'd10}
    };
    post = '{
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0,     16'd0,     6'b000001, 16'd0,     16'd0},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0,     16'd0,     6'b000001, 16'd0,     16'd0},
      '{1'b0, 8'd0, 1'b0, 1'b1, 16'hFFFF,  16'hFFFF,  6'b000001, 16'd0,     16'd0},
      '{1'b1, 8'd1, 1'b0, 1'b0, 16'd0,     16'd0,     6'b000001, 16'd0,     16'd0},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0,     16'd0,     6'b010101, 16'd0,     16'd0},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0,     16'd0,     6'b101101, 16'hFFFF,  16'hFFFF},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0,     16'd0,     6'b000111, 16'hFFFF,  16'hFFFF},
      '{1'b0, 8'd0, 1'b0, 1'b0, 16'd0,     16'd0,     6'b000001, 16'hFFFF,  16'hFFFF}
    };
    #1;
    check("reset_state", {26'd0, op_valid, acc_clear, op_last, busy, done, in_ready, multiplier, multiplicand},
          {26'd0, 6'b000001, 32'd0});
    @(posedge clk);
    #1;
    rst = 1'b1;
    foreach (basic[i]) apply($sformatf("basic%0d", i), basic[i]);
    check("basic_mac", {32'd0, acc}, {32'd0, 32'd68});
    issues = 0;
    foreach (starve[i]) apply($sformatf("starve%0d", i), starve[i]);
    check("starve_issues", 64'(issues), 64'd4);
    check("starve_mac", {32'd0, acc}, {32'd0, 32'd300});
    foreach (full[i]) apply($sformatf("full%0d", i), full[i]);
    foreach (fill[i]) apply($sformatf("fill%0d", i), fill[i]);
    issues = 0;
    foreach (zero[i]) apply($sformatf("zero%0d", i), zero[i]);
    check("zero_issues", 64'(issues), 64'd0);
    foreach (ign[i]) apply($sformatf("ignore%0d", i), ign[i]);
    foreach (pre[i]) apply($sformatf("prereset%0d", i), pre[i]);
    rst = 1'b0;
    #1;
    check("reset_async", {26'd0, op_valid, acc_clear, op_last, busy, done, in_ready, multiplier, multiplicand},
          {26'd0, 6'b000001, 32'd0});
    @(posedge clk);
    #1;
    check("reset_held", {26'd0, op_valid, acc_clear, op_last, busy, done, in_ready, multiplier, multiplicand},
          {26'd0, 6'b000001, 32'd0});
    rst = 1'b1;
    foreach (post[i]) apply($sformatf("postreset%0d", i), post[i]);
    check("post_mac", {32'd0, acc}, {32'd0, 32'hFFFE0001});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
